time_setup_editor: RTL

- Button-driven time editor. It produces the 24-bit setup word {hour, min, sec} that the 7-segment display path shows in setup mode and that the timekeeper loads.
- Sits between the board push-buttons and the clock core.
- Captures the current time, lets the user step through hour/min/sec fields with up/down buttons, then issues a one-cycle load strobe.

---
 rtl/time_setup_editor_if.sv | 24 ++
 rtl/time_setup_editor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/time_setup_editor_if.sv
// Button/time bundle between the board front-end and the time setup editor.
// master: the side driving the buttons and the running time (board/clock core).
// slave : the editor itself.
interface time_setup_editor_if;
  logic        btn_mode;
  logic        btn_up;
  logic        btn_down;
  logic [23:0] cur_time;
  logic [23:0] setup_data;
  logic [1:0]  setup_field;
  logic        setup_active;
  logic        load_strobe;
  logic        blink;

  modport master (
    output btn_mode, btn_up, btn_down, cur_time,
    input  setup_data, setup_field, setup_active, load_strobe, blink
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, cur_time,
    output setup_data, setup_field, setup_active, load_strobe, blink
  );
endinterface

// File: rtl/time_setup_editor.sv
// Button-driven {hour, min, sec} editor. Captures cur_time on a mode press,
// steps the active field with up/down, and pulses load_strobe on leaving SEC.
// Optional build macro: AUTOREPEAT_EN (held up/down generates repeated steps).
module time_setup_editor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  time_setup_editor_if.slave   bus
);

  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (BLINK_CYCLES >= 1) &&
                             (REPEAT_PERIOD >= 1) && (REPEAT_PERIOD <= REPEAT_DELAY);

  if (!PARAMS_OK) begin : g_param_check
    $error("time_setup_editor: illegal parameter combination");
  end

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  localparam int BCW = $clog2(BLINK_CYCLES + 1);
  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOUR = 2'd1,
    MIN  = 2'd2,
    SEC  = 2'd3
  } state_t;

  // Button index: 0 = mode, 1 = up, 2 = down.
  logic [2:0]     raw;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     deb;
  logic [2:0]     press;
  logic [DCW-1:0] db_cnt [3];

  logic           step_up;
  logic           step_down;

  state_t         state;
  state_t         state_n;
  logic [23:0]    data;
  logic [23:0]    data_n;
  logic           strobe;
  logic           strobe_n;
  logic           restart;
  logic           blink_q;
  logic [BCW-1:0] blink_cnt;

  assign raw = {bus.btn_down, bus.btn_up, bus.btn_mode};

  function automatic logic [7:0] clamp_field(input logic [7:0] v, input logic [7:0] max_v);
    return (v > max_v) ? 8'd0 : v;
  endfunction

  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] max_v,
                                            input logic inc);
    if (inc) return (v == max_v) ? 8'd0 : v + 8'd1;
    else     return (v == 8'd0) ? max_v : v - 8'd1;
  endfunction

  // Synchronise, debounce and edge-detect the three buttons.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // Press pulse is registered together with the level so it lasts one cycle.
          deb[i]    <= sync2[i];
          press[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RCW-1:0] REP_FIRE   = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] REP_RELOAD = RCW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [RCW-1:0] rep_cnt [2];
  logic [1:0]     rep;

  // Hold timers for up (0) and down (1); holding both suppresses repeats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep <= '0;
      for (int unsigned j = 0; j < 2; j++) rep_cnt[j] <= '0;
    end else begin
      rep <= '0;
      for (int unsigned j = 0; j < 2; j++) begin
        if (!deb[j + 1]) begin
          rep_cnt[j] <= '0;
        end else if (rep_cnt[j] == REP_FIRE) begin
          // Reload so later repeats arrive every REPEAT_PERIOD clocks.
          rep[j]     <= ~deb[2 - j];
          rep_cnt[j] <= REP_RELOAD;
        end else begin
          rep_cnt[j] <= rep_cnt[j] + 1'b1;
        end
      end
    end
  end

  assign step_up   = press[1] | rep[0];
  assign step_down = press[2] | rep[1];
`else
  assign step_up   = press[1];
  assign step_down = press[2];
`endif

  // Next-state, edited word and strobe; mode wins over a coincident step.
  always_comb begin
    state_n  = state;
    data_n   = data;
    strobe_n = 1'b0;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (press[0]) begin
          state_n = HOUR;
          data_n  = {clamp_field(bus.cur_time[23:16], 8'd23),
                     clamp_field(bus.cur_time[15:8],  8'd59),
                     clamp_field(bus.cur_time[7:0],   8'd59)};
          restart = 1'b1;
        end
      end
      HOUR: begin
        if (press[0]) begin
          state_n = MIN;
          restart = 1'b1;
        end else if (step_up ^ step_down) begin
          data_n[23:16] = step_field(data[23:16], 8'd23, step_up);
          restart       = 1'b1;
        end
      end
      MIN: begin
        if (press[0]) begin
          state_n = SEC;
          restart = 1'b1;
        end else if (step_up ^ step_down) begin
          data_n[15:8] = step_field(data[15:8], 8'd59, step_up);
          restart      = 1'b1;
        end
      end
      SEC: begin
        if (press[0]) begin
          state_n  = IDLE;
          strobe_n = 1'b1;
          restart  = 1'b1;
        end else if (step_up ^ step_down) begin
          data_n[7:0] = step_field(data[7:0], 8'd59, step_up);
          restart     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, edited word and load strobe registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      data   <= '0;
      strobe <= 1'b0;
    end else begin
      state  <= state_n;
      data   <= data_n;
      strobe <= strobe_n;
    end
  end

  // Blink phase: solid in IDLE, restarted solid on any field change or step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (state_n == IDLE || restart) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_q   <= ~blink_q;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.setup_data   = data;
  assign bus.setup_field  = state;
  assign bus.setup_active = (state != IDLE);
  assign bus.load_strobe  = strobe;
  assign bus.blink        = blink_q;

endmodule
